// File: rtl/rvc_asap_5pl_dmem_arb.sv
// ----------------------------------------------------------------------------
// rvc_asap_5pl_dmem_arb
// Arbiter for the single shared data-memory port between the core (Q103H
// stage access) and an external loader/debug requester.
//
// - The grant is combinational from the current requests and registered
//   state. The core wins by default. After STARVE_MAX back-to-back core
//   grants with the external request pending, the external requester wins
//   one beat.
// - Each read return is steered to whichever requester issued the read on
//   the previous cycle. This allows back-to-back reads with alternating
//   owners.
// - Optional lock feature, enabled by the macro RVC_ASAP_DMEM_ARB_LOCK_EN.
//   While ExtLock is held on granted external beats, the port is kept for
//   the external requester.
//
// Ports
//   Clock, RstN                 clock, async active-low reset
//   Core{Req,WrEn,Addr,WrData,ByteEn}   core request payload
//   CoreStall                   core request not granted this cycle
//   CoreRdValid/CoreRdData      core read return (one cycle after issue)
//   Ext{Req,WrEn,Addr,WrData,ByteEn}    external request payload
//   ExtLock                     hold the port across beats (lock build only)
//   ExtGnt                      external request accepted this cycle
//   ExtRdValid/ExtRdData        external read return
//   Mem{RdEn,WrEn,Addr,WrData,ByteEn}   shared memory port
//   MemRdData                   memory read data, one cycle after MemRdEn
//
// Parameter
//   STARVE_MAX  max consecutive core grants while external waits (1..15)
// ----------------------------------------------------------------------------
module rvc_asap_5pl_dmem_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clock,
  input  logic        RstN,
  // core side
  input  logic        CoreReq,
  input  logic        CoreWrEn,
  input  logic [31:0] CoreAddr,
  input  logic [31:0] CoreWrData,
  input  logic [3:0]  CoreByteEn,
  output logic        CoreStall,
  output logic        CoreRdValid,
  output logic [31:0] CoreRdData,
  // external side
  input  logic        ExtReq,
  input  logic        ExtWrEn,
  input  logic [31:0] ExtAddr,
  input  logic [31:0] ExtWrData,
  input  logic [3:0]  ExtByteEn,
  input  logic        ExtLock,
  output logic        ExtGnt,
  output logic        ExtRdValid,
  output logic [31:0] ExtRdData,
  // shared memory port
  output logic        MemRdEn,
  output logic        MemWrEn,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWrData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRdData
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 4;

  // Request payload steered onto the shared port
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } mem_req_t;

  // State records which requester was granted on the previous cycle
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE     = 2'd1,
    EXT      = 2'd2,
    EXT_LOCK = 2'd3
  } state_e;

  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          core_rd_q, core_rd_d;
  logic          ext_rd_q, ext_rd_d;

  logic          core_gnt_c;
  logic          ext_gnt_c;
  logic          lock_c;
  mem_req_t      core_pl_c;
  mem_req_t      ext_pl_c;
  mem_req_t      mem_req_c;

  // EXT_LOCK is only ever entered in the lock build, so this is constant
  // false otherwise.
  assign lock_c = (state_q == EXT_LOCK);

`ifndef RVC_ASAP_DMEM_ARB_LOCK_EN
  logic unused_ext_lock;
  assign unused_ext_lock = ExtLock;
`endif

  // State, starvation counter and read-owner registers
  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      core_rd_q <= 1'b0;
      ext_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      core_rd_q <= core_rd_d;
      ext_rd_q  <= ext_rd_d;
    end
  end

  // Grant decision, next state and starvation counter
  always_comb begin
    core_gnt_c = 1'b0;
    ext_gnt_c  = 1'b0;
    state_d    = IDLE;
    starve_d   = starve_q;

    // Nothing is granted while reset is asserted, so every port stays quiet.
    if (RstN) begin
      if (lock_c) begin
        ext_gnt_c = ExtReq;
      end else if (CoreReq && ExtReq) begin
        if (starve_q == STARVE_LIMIT) begin
          ext_gnt_c = 1'b1;
        end else begin
          core_gnt_c = 1'b1;
        end
      end else begin
        core_gnt_c = CoreReq;
        ext_gnt_c  = ExtReq;
      end
    end

    if (core_gnt_c) begin
      state_d = CORE;
    end else if (ext_gnt_c) begin
`ifdef RVC_ASAP_DMEM_ARB_LOCK_EN
      state_d = ExtLock ? EXT_LOCK : EXT;
`else
      state_d = EXT;
`endif
    end

    // Count core wins only while the external requester is waiting.
    if (!ExtReq || ext_gnt_c || lock_c) begin
      starve_d = '0;
    end else if (core_gnt_c && (starve_q < STARVE_LIMIT)) begin
      starve_d = starve_q + CW'(1);
    end

    core_rd_d = core_gnt_c & ~CoreWrEn;
    ext_rd_d  = ext_gnt_c & ~ExtWrEn;
  end

  // Payload mux onto the shared port
  always_comb begin
    core_pl_c = '{we: CoreWrEn, addr: CoreAddr, wdata: CoreWrData, be: CoreByteEn};
    ext_pl_c  = '{we: ExtWrEn,  addr: ExtAddr,  wdata: ExtWrData,  be: ExtByteEn};
    mem_req_c = '0;
    if (core_gnt_c) begin
      mem_req_c = core_pl_c;
    end else if (ext_gnt_c) begin
      mem_req_c = ext_pl_c;
    end
  end

  assign MemWrEn   = mem_req_c.we;
  assign MemRdEn   = (core_gnt_c | ext_gnt_c) & ~mem_req_c.we;
  assign MemAddr   = mem_req_c.addr;
  assign MemWrData = mem_req_c.wdata;
  assign MemByteEn = mem_req_c.be;

  assign CoreStall = RstN & CoreReq & ~core_gnt_c;
  assign ExtGnt    = ext_gnt_c;

  // Return data goes only to the owner recorded at issue time.
  assign CoreRdValid = core_rd_q;
  assign CoreRdData  = core_rd_q ? MemRdData : '0;
  assign ExtRdValid  = ext_rd_q;
  assign ExtRdData   = ext_rd_q ? MemRdData : '0;

endmodule

// File: tb/tb_rvc_asap_5pl_dmem_arb.sv
module tb_rvc_asap_5pl_dmem_arb;

  logic        Clock;
  logic        RstN;
  logic        CoreReq, CoreWrEn;
  logic [31:0] CoreAddr, CoreWrData;
  logic [3:0]  CoreByteEn;
  logic        CoreStall, CoreRdValid;
  logic [31:0] CoreRdData;
  logic        ExtReq, ExtWrEn;
  logic [31:0] ExtAddr, ExtWrData;
  logic [3:0]  ExtByteEn;
  logic        ExtLock;
  logic        ExtGnt, ExtRdValid;
  logic [31:0] ExtRdData;
  logic        MemRdEn, MemWrEn;
  logic [31:0] MemAddr, MemWrData;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRdData;

  rvc_asap_5pl_dmem_arb #(.STARVE_MAX(4)) dut (
    .Clock       (Clock),
    .RstN        (RstN),
    .CoreReq     (CoreReq),
    .CoreWrEn    (CoreWrEn),
    .CoreAddr    (CoreAddr),
    .CoreWrData  (CoreWrData),
    .CoreByteEn  (CoreByteEn),
    .CoreStall   (CoreStall),
    .CoreRdValid (CoreRdValid),
    .CoreRdData  (CoreRdData),
    .ExtReq      (ExtReq),
    .ExtWrEn     (ExtWrEn),
    .ExtAddr     (ExtAddr),
    .ExtWrData   (ExtWrData),
    .ExtByteEn   (ExtByteEn),
    .ExtLock     (ExtLock),
    .ExtGnt      (ExtGnt),
    .ExtRdValid  (ExtRdValid),
    .ExtRdData   (ExtRdData),
    .MemRdEn     (MemRdEn),
    .MemWrEn     (MemWrEn),
    .MemAddr     (MemAddr),
    .MemWrData   (MemWrData),
    .MemByteEn   (MemByteEn),
    .MemRdData   (MemRdData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        rst_n;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic [3:0]  cbe;
    logic        ereq;
    logic        ewe;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic        elock;
    logic [31:0] mrd;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic        crv;
    logic [31:0] crd;
    logic        egnt;
    logic        erv;
    logic [31:0] erd;
    logic        mre;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mbe;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic in_t ci(logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                             logic [3:0] cbe, logic ereq, logic ewe, logic [31:0] eaddr,
                             logic [31:0] ewd, logic [3:0] ebe, logic [31:0] mrd);
    return '{1'b1, creq, cwe, caddr, cwd, cbe, ereq, ewe, eaddr, ewd, ebe, 1'b0, mrd};
  endfunction

  function automatic out_t co(logic stall, logic crv, logic [31:0] crd, logic egnt,
                              logic erv, logic [31:0] erd, logic mre, logic mwe,
                              logic [31:0] maddr, logic [31:0] mwd, logic [3:0] mbe);
    return '{stall, crv, crd, egnt, erv, erd, mre, mwe, maddr, mwd, mbe};
  endfunction

  function automatic in_t idle(logic [31:0] mrd);
    return ci(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, mrd);
  endfunction

  function automatic out_t sample();
    return '{CoreStall, CoreRdValid, CoreRdData, ExtGnt, ExtRdValid, ExtRdData,
             MemRdEn, MemWrEn, MemAddr, MemWrData, MemByteEn};
  endfunction

  task automatic drive(input in_t v);
    RstN       = v.rst_n;
    CoreReq    = v.creq;
    CoreWrEn   = v.cwe;
    CoreAddr   = v.caddr;
    CoreWrData = v.cwd;
    CoreByteEn = v.cbe;
    ExtReq     = v.ereq;
    ExtWrEn    = v.ewe;
    ExtAddr    = v.eaddr;
    ExtWrData  = v.ewd;
    ExtByteEn  = v.ebe;
    ExtLock    = v.elock;
    MemRdData  = v.mrd;
  endtask

  // Drive just after the rising edge, observe on the falling edge.
  task automatic step(input in_t v);
    @(posedge Clock);
    #1;
    drive(v);
    @(negedge Clock);
  endtask

  task automatic chk_vec(input string nm, input out_t exp);
    out_t act;
    act = sample();
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  initial begin
    in_t b, r, l;
    logic lock_build;
`ifdef RVC_ASAP_DMEM_ARB_LOCK_EN
    lock_build = 1'b1;
`else
    lock_build = 1'b0;
`endif

    r = idle(32'h0);
    r.rst_n = 1'b0;
    drive(r);

    // reset holds everything at zero even with both requesting
    r = ci(1'b1, 1'b1, 32'h1234, 32'h5678, 4'hF, 1'b1, 1'b1, 32'h9999, 32'h7777, 4'hF, 32'hCAFE);
    r.rst_n = 1'b0;
    tbl.push_back('{r, out_t'('0)});
    tbl.push_back('{idle(32'h0), out_t'('0)});
    // core read then its return
    tbl.push_back('{ci(1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0),
                    co(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hF)});
    tbl.push_back('{idle(32'hDEADBEEF),
                    co(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0)});
    // core write, no return afterwards
    tbl.push_back('{ci(1'b1, 1'b1, 32'h40, 32'h11223344, 4'h3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0),
                    co(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h11223344, 4'h3)});
    tbl.push_back('{idle(32'hFFFFFFFF), out_t'('0)});
    // alternating owners, back to back
    tbl.push_back('{ci(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0),
                    co(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF)});
    tbl.push_back('{ci(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 32'hAAAA0001),
                    co(1'b0, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF)});
    tbl.push_back('{idle(32'hBBBB0002),
                    co(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB0002, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0)});
    // external write alone
    tbl.push_back('{ci(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h80, 32'h55, 4'h1, 32'h0),
                    co(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h55, 4'h1)});
    // starvation: four core grants, then one external, then core again
    b = ci(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1, 1'b0, 32'h200, 32'h0, 4'hC, 32'h10);
    tbl.push_back('{b, co(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF)});
    for (int k = 1; k <= 3; k++) begin
      b.mrd = 32'h10 + 32'(k);
      tbl.push_back('{b, co(1'b0, 1'b1, b.mrd, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF)});
    end
    b.mrd = 32'h14;
    tbl.push_back('{b, co(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hC)});
    b.mrd = 32'h15;
    tbl.push_back('{b, co(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h15, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF)});
    tbl.push_back('{ci(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h16),
                    co(1'b0, 1'b1, 32'h16, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF)});
    tbl.push_back('{idle(32'h17),
                    co(1'b0, 1'b1, 32'h17, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0)});

    foreach (tbl[k]) begin
      step(tbl[k].i);
      chk_vec($sformatf("vec%0d", k), tbl[k].o);
    end

    // reset in the cycle the core read return is due
    b = ci(1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b1, 1'b0, 32'h200, 32'h0, 4'hC, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(b);
      chk($sformatf("pre_rst_core%0d", k), 32'(CoreStall), 32'h0);
    end
    r = b;
    r.rst_n = 1'b0;
    r.mrd   = 32'hDEADBEEF;
    step(r);
    chk_vec("rst_mid_read", out_t'('0));
    step(idle(32'hDEADBEEF));
    chk_vec("rst_no_stale", out_t'('0));
    // starvation count restarts from zero after reset
    for (int k = 0; k < 4; k++) begin
      step(b);
      chk($sformatf("post_rst_core%0d", k), 32'({CoreStall, ExtGnt, MemRdEn}), 32'b001);
    end
    step(b);
    chk("post_rst_ext", 32'({CoreStall, ExtGnt, MemAddr == 32'h200}), 32'b111);
    step(idle(32'h0));

    // lock: three locked external beats plus the unlocking beat
    l = ci(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h300, 32'hA, 4'hF, 32'h0);
    l.elock = 1'b1;
    step(l);
    chk("lock_beat0", 32'({CoreStall, ExtGnt}), 32'b01);
    l.creq  = 1'b1;
    l.caddr = 32'h100;
    l.cbe   = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) l.elock = 1'b0;
      step(l);
      chk($sformatf("lock_beat%0d", k), 32'({CoreStall, ExtGnt}),
          lock_build ? 32'b11 : 32'b00);
    end
    l.ereq = 1'b0;
    step(l);
    chk("lock_release_core", 32'({CoreStall, ExtGnt, MemRdEn}), 32'b001);
    step(idle(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
